// File: rtl/matrix_mac_scheduler.sv
// Purpose : two-requester round-robin scheduler around one shared 2x2 matrix multiply-accumulate engine.
// Latency : done pulse 8 edges after the grant edge; one operation per 10 cycles at best.
// Backpres: requests are level-held until gnt; nothing is queued while busy, held requests are seen in IDLE.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   req0/a0/b0           requester 0 request (level) and packed operands {m00,m01,m10,m11}
//   req1/a1/b1           requester 1 request (level) and packed operands
//   gnt0/gnt1            one-cycle grant pulse; operands latched on that same edge
//   done0/done1          one-cycle completion pulse to the granted requester
//   res                  shared result C = A x B, low DW bits per element, held until next done
//   ovf                  set with done when any element's full sum exceeded 2^DW-1
//   busy                 high from grant edge until the return to IDLE
module matrix_mac_scheduler #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [4*DW-1:0] a0,
   input  logic [4*DW-1:0] b0,
   input  logic            req1,
   input  logic [4*DW-1:0] a1,
   input  logic [4*DW-1:0] b1,
   output logic            gnt0,
   output logic            gnt1,
   output logic            done0,
   output logic            done1,
   output logic [4*DW-1:0] res,
   output logic            ovf,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [2:0]              step;
   logic                    last;      // last-served requester; also owner of the in-flight op
   logic [4*DW-1:0]         a_q;
   logic [4*DW-1:0]         b_q;
   logic [2*DW:0]           acc;
   logic [3:0][DW-1:0]      buf_q;     // index 3 holds c00, index 0 holds c11 (matches packing)
   logic                    ovf_flag;

   logic [3:0][DW-1:0]      a_m;
   logic [3:0][DW-1:0]      b_m;
   logic [1:0]              elem;
   logic [DW-1:0]           a_el;
   logic [DW-1:0]           b_el;
   logic [2*DW-1:0]         prod;
   logic [2*DW:0]           sum;
   logic                    sum_ovf;
   logic                    win;

   assign a_m  = a_q;
   assign b_m  = b_q;

   // step = {element row, element col, k}: element (i,j) uses a[i][k] * b[k][j].
   // Packed index of m[r][c] is 2r+c counted from the MSB end, hence the inversion.
   assign elem    = step[2:1];
   assign a_el    = a_m[~{elem[1], step[0]}];
   assign b_el    = b_m[~{step[0], elem[0]}];
   assign prod    = a_el * b_el;
   assign sum     = acc + {1'b0, prod};
   assign sum_ovf = |sum[2*DW:DW];

   // Lone requester always wins; on a tie the one not served last wins.
   assign win = (req0 && req1) ? ~last : req1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         step     <= '0;
         last     <= 1'b1;   // requester 0 wins the first contest
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         buf_q    <= '0;
         ovf_flag <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         res      <= '0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  last     <= win;
                  gnt0     <= ~win;
                  gnt1     <= win;
                  a_q      <= win ? a1 : a0;
                  b_q      <= win ? b1 : b0;
                  busy     <= 1'b1;
                  step     <= '0;
                  ovf_flag <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               step <= step + 3'd1;
               if (!step[0]) begin
                  acc <= {1'b0, prod};
               end else begin
                  buf_q[~elem] <= sum[DW-1:0];
                  if (sum_ovf) ovf_flag <= 1'b1;
               end
               // Last step: c11 is being produced this edge, so bypass it straight into res.
               if (step == 3'd7) begin
                  state <= DONE;
                  res   <= {buf_q[3], buf_q[2], buf_q[1], sum[DW-1:0]};
                  ovf   <= ovf_flag | sum_ovf;
                  done0 <= ~last;
                  done1 <= last;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mac_scheduler.sv
module tb_matrix_mac_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, done0, done1, ovf, busy;
   logic [31:0] res;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   matrix_mac_scheduler #(.DW(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .res(res), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model: plain 2x2 matrix arithmetic ----------------
   function automatic int el(input logic [31:0] m, input int idx);
      return int'((m >> (8 * (3 - idx))) & 32'hFF);
   endfunction

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
      int s;
      r = '0;
      o = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = el(a, 2*i) * el(b, j) + el(a, 2*i+1) * el(b, 2+j);
            if (s > 255) o = 1'b1;
            r = r | 32'((s & 255) << (8 * (3 - (2*i + j))));
         end
   endfunction

   function automatic logic [31:0] rand_mat();
      logic [31:0] m;
      m = $urandom;
      if ($urandom_range(0, 2) == 0) m = m & 32'h0F0F0F0F;
      return m;
   endfunction

   task automatic apply_reset();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Drives one request and observes it to completion; the calling tests do the comparisons.
   task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output bit to, output int lat, output logic [31:0] r_res, output logic r_ovf,
                        output logic [31:0] res_next, output logic busy_done, output logic busy_next,
                        output bit overlap);
      int  g;
      bit  got;
      to = 1'b1; lat = -1; r_res = 'x; r_ovf = 1'bx; res_next = 'x;
      busy_done = 1'bx; busy_next = 1'bx; overlap = 1'b0; got = 1'b0; g = 0;
      if (r == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
      else        begin a1 = a; b1 = b; req1 = 1'b1; end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if ((gnt0 && gnt1) || (done0 && done1)) overlap = 1'b1;
         if (!got && (r == 0 ? gnt0 : gnt1)) begin
            got = 1'b1; g = cyc;
            if (r == 0) req0 = 1'b0; else req1 = 1'b0;
            if (scramble) begin
               if (r == 0) begin a0 = $urandom; b0 = $urandom; end
               else        begin a1 = $urandom; b1 = $urandom; end
            end
         end else if (got && (r == 0 ? done0 : done1)) begin
            lat = cyc - g; r_res = res; r_ovf = ovf; busy_done = busy; to = 1'b0;
            break;
         end
      end
      if (!to) begin
         @(posedge clk); #1;
         if ((gnt0 && gnt1) || (done0 && done1)) overlap = 1'b1;
         res_next = res; busy_next = busy;
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; #1;
      checks++;
      if ({gnt0, gnt1, done0, done1, busy, ovf, res} !== 38'd0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", {gnt0, gnt1, done0, done1, busy, ovf, res});
      end
      apply_reset();
      @(posedge clk); #1;
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_idle: got %b required 000", {gnt0, gnt1, busy});
      end
   endtask

   task automatic test_basic();
      bit to, ov; int lat; logic [31:0] r, rn; logic o, bd, bn;
      apply_reset();
      do_op(0, 32'h01020304, 32'h05060708, 1'b0, to, lat, r, o, rn, bd, bn, ov);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: no done0 within budget"); end
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
      checks++;
      if (r !== 32'h13162B32 || o !== 1'b0) begin
         errors++; $display("FAIL basic_result: got res=%h ovf=%b required 13162b32 ovf=0", r, o);
      end
      checks++;
      if (bd !== 1'b1 || bn !== 1'b0) begin
         errors++; $display("FAIL basic_busy: got done=%b next=%b required 1 0", bd, bn);
      end
      checks++;
      if (rn !== 32'h13162B32) begin errors++; $display("FAIL basic_hold: got %h required 13162b32", rn); end
   endtask

   task automatic test_overflow();
      bit to, ov; int lat; logic [31:0] r, rn; logic o, bd, bn;
      do_op(0, 32'hFFFF0000, 32'hFF00FF00, 1'b0, to, lat, r, o, rn, bd, bn, ov);
      checks++;
      if (to || r !== 32'h02000000 || o !== 1'b1) begin
         errors++; $display("FAIL overflow: got to=%b res=%h ovf=%b required to=0 res=02000000 ovf=1", to, r, o);
      end
      checks++;
      if (rn !== 32'h02000000) begin errors++; $display("FAIL overflow_hold: got %h required 02000000", rn); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] x0, y0, x1, y1, e0, e1, r0, r1;
      logic o0, o1, eo0, eo1;
      int g0, g1, d0, d1;
      bit overlap;
      apply_reset();
      x0 = rand_mat(); y0 = rand_mat(); x1 = rand_mat(); y1 = rand_mat();
      model(x0, y0, e0, eo0); model(x1, y1, e1, eo1);
      a0 = x0; b0 = y0; a1 = x1; b1 = y1; req0 = 1'b1; req1 = 1'b1;
      g0 = -1; g1 = -1; d0 = -1; d1 = -1; overlap = 1'b0; r0 = '0; r1 = '0; o0 = 1'b0; o1 = 1'b0;
      for (int i = 0; i < 60 && d1 < 0; i++) begin
         @(posedge clk); #1;
         if ((gnt0 && gnt1) || (done0 && done1)) overlap = 1'b1;
         if (gnt0 && g0 < 0) begin g0 = cyc; req0 = 1'b0; a0 = $urandom; end
         if (gnt1 && g1 < 0) begin g1 = cyc; req1 = 1'b0; a1 = $urandom; end
         if (done0 && d0 < 0) begin d0 = cyc; r0 = res; o0 = ovf; end
         if (done1 && d1 < 0) begin d1 = cyc; r1 = res; o1 = ovf; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (g0 < 0 || g1 < 0 || d0 < 0 || d1 < 0) begin
         errors++; $display("FAIL sim_timeout: g0=%0d g1=%0d d0=%0d d1=%0d required all seen", g0, g1, d0, d1);
      end
      checks++;
      if (g1 - g0 !== 10 || d0 - g0 !== 8 || d1 - g1 !== 8) begin
         errors++; $display("FAIL sim_order: got g1-g0=%0d d0-g0=%0d d1-g1=%0d required 10 8 8", g1-g0, d0-g0, d1-g1);
      end
      checks++;
      if (r0 !== e0 || o0 !== eo0) begin errors++; $display("FAIL sim_res0: got %h/%b required %h/%b", r0, o0, e0, eo0); end
      checks++;
      if (r1 !== e1 || o1 !== eo1) begin errors++; $display("FAIL sim_res1: got %h/%b required %h/%b", r1, o1, e1, eo1); end
      checks++;
      if (overlap) begin errors++; $display("FAIL sim_overlap: got 1 required 0"); end
   endtask

   task automatic test_busy_request();
      logic [31:0] x1, y1, e1, r1; logic eo1, o1;
      int g0, g1, d1; bit early;
      apply_reset();
      x1 = rand_mat(); y1 = rand_mat(); model(x1, y1, e1, eo1);
      a0 = rand_mat(); b0 = rand_mat(); req0 = 1'b1;
      g0 = -1; g1 = -1; d1 = -1; early = 1'b0; r1 = '0; o1 = 1'b0;
      for (int i = 0; i < 60 && d1 < 0; i++) begin
         @(posedge clk); #1;
         if (gnt0 && g0 < 0) begin g0 = cyc; req0 = 1'b0; end
         if (g0 >= 0 && cyc == g0 + 3) begin a1 = x1; b1 = y1; req1 = 1'b1; end
         if (gnt1 && g1 < 0) begin
            g1 = cyc; req1 = 1'b0;
            if (g1 - g0 < 10) early = 1'b1;
         end
         if (done1 && d1 < 0) begin d1 = cyc; r1 = res; o1 = ovf; end
      end
      req1 = 1'b0;
      checks++;
      if (early || g1 - g0 !== 10) begin
         errors++; $display("FAIL busy_req_grant: got gnt1 at +%0d required +10", g1 - g0);
      end
      checks++;
      if (d1 < 0 || r1 !== e1 || o1 !== eo1) begin
         errors++; $display("FAIL busy_req_result: got %h/%b required %h/%b", r1, o1, e1, eo1);
      end
   endtask

   task automatic test_reset_mid();
      bit to, ov, seen_done; int lat; logic [31:0] x, y, e, r, rn; logic eo, o, bd, bn;
      int g0;
      apply_reset();
      a0 = rand_mat(); b0 = rand_mat(); req0 = 1'b1; g0 = -1; seen_done = 1'b0;
      for (int i = 0; i < 20 && g0 < 0; i++) begin
         @(posedge clk); #1;
         if (gnt0) begin g0 = cyc; req0 = 1'b0; end
      end
      repeat (4) begin @(posedge clk); #1; if (done0 || done1) seen_done = 1'b1; end
      rst = 1'b0; #1;
      checks++;
      if ({gnt0, gnt1, done0, done1, busy, ovf, res} !== 38'd0) begin
         errors++; $display("FAIL midreset_outputs: got %h required 0", {gnt0, gnt1, done0, done1, busy, ovf, res});
      end
      repeat (3) begin @(posedge clk); #1; if (done0 || done1) seen_done = 1'b1; end
      rst = 1'b1;
      repeat (12) begin @(posedge clk); #1; if (done0 || done1) seen_done = 1'b1; end
      checks++;
      if (g0 < 0 || seen_done) begin errors++; $display("FAIL midreset_nodone: got gnt=%0d done=%b required done=0", g0, seen_done); end
      x = rand_mat(); y = rand_mat(); model(x, y, e, eo);
      do_op(1, x, y, 1'b0, to, lat, r, o, rn, bd, bn, ov);
      checks++;
      if (to || lat !== 8 || r !== e || o !== eo) begin
         errors++; $display("FAIL midreset_after: got to=%b lat=%0d res=%h ovf=%b required 8 %h %b", to, lat, r, o, e, eo);
      end
   endtask

   task automatic test_operand_change();
      bit to, ov; int lat; logic [31:0] x, y, e, r, rn; logic eo, o, bd, bn;
      for (int k = 0; k < 3; k++) begin
         x = rand_mat(); y = rand_mat(); model(x, y, e, eo);
         do_op(0, x, y, 1'b1, to, lat, r, o, rn, bd, bn, ov);
         checks++;
         if (to || r !== e || o !== eo) begin
            errors++; $display("FAIL operand_change: got to=%b res=%h ovf=%b required %h %b", to, r, o, e, eo);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x2, y2, e2, r2; logic eo2, o2;
      int g1st, g2nd, d2;
      apply_reset();
      x2 = rand_mat(); y2 = rand_mat(); model(x2, y2, e2, eo2);
      a0 = rand_mat(); b0 = rand_mat(); req0 = 1'b1;
      g1st = -1; g2nd = -1; d2 = -1; r2 = '0; o2 = 1'b0;
      for (int i = 0; i < 60 && d2 < 0; i++) begin
         @(posedge clk); #1;
         if (gnt0 && g1st < 0) begin g1st = cyc; a0 = x2; b0 = y2; end
         else if (gnt0 && g2nd < 0) begin g2nd = cyc; req0 = 1'b0; end
         if (done0 && g2nd >= 0 && d2 < 0) begin d2 = cyc; r2 = res; o2 = ovf; end
      end
      req0 = 1'b0;
      checks++;
      if (g2nd - g1st !== 10 || d2 - g2nd !== 8) begin
         errors++; $display("FAIL b2b_timing: got regrant +%0d done +%0d required +10 +8", g2nd - g1st, d2 - g2nd);
      end
      checks++;
      if (r2 !== e2 || o2 !== eo2) begin errors++; $display("FAIL b2b_result: got %h/%b required %h/%b", r2, o2, e2, eo2); end
   endtask

   task automatic test_random();
      bit to, ov; int lat, rq; logic [31:0] x, y, e, r, rn; logic eo, o, bd, bn;
      for (int k = 0; k < 20; k++) begin
         rq = $urandom_range(0, 1);
         x = rand_mat(); y = rand_mat(); model(x, y, e, eo);
         do_op(rq, x, y, 1'b0, to, lat, r, o, rn, bd, bn, ov);
         checks++;
         if (to || lat !== 8 || r !== e || o !== eo || rn !== e || bd !== 1'b1 || bn !== 1'b0 || ov) begin
            errors++;
            $display("FAIL random_%0d: req%0d to=%b lat=%0d res=%h ovf=%b hold=%h busy=%b%b ovl=%b required lat=8 res=%h ovf=%b busy=10",
                     k, rq, to, lat, r, o, rn, bd, bn, ov, e, eo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_simultaneous();
      test_busy_request();
      test_reset_mid();
      test_operand_change();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_mac_scheduler.md
MATRIX_MAC_SCHEDULER -- requirements
Module: matrix_mac_scheduler

Interface
REQ-001 Parameter: DW, default 8, element width in bits; packed matrix ports are 4*DW wide.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 operation request, level, held until gnt0.
REQ-005 a0, b0  input  4*DW  requester 0 operands; packing {m00,m01,m10,m11}, m00 in MSBs.
REQ-006 req1  input  1  requester 1 operation request, level, held until gnt1.
REQ-007 a1, b1  input  4*DW  requester 1 operands, same packing.
REQ-008 gnt0, gnt1  output  1  one-cycle grant pulse; operands latched on the same edge.
REQ-009 done0, done1  output  1  one-cycle completion pulse to the granted requester.
REQ-010 res  output  4*DW  shared result C = A x B, same packing, low DW bits per element.
REQ-011 ovf  output  1  high with done when any element's full sum exceeded 2^DW-1.
REQ-012 busy  output  1  high from the grant edge until return to IDLE.

Function
REQ-013 States SHALL be IDLE, MAC, DONE; all outputs registered.
REQ-014 IDLE, any req high at edge E0: SHALL grant one requester, assert its gnt for one cycle, latch its a/b, set busy, clear step counter, go to MAC.
REQ-015 Arbitration SHALL be round-robin on a last-served pointer; a lone requester is always granted; when both request, the one not last served wins.
REQ-016 The pointer SHALL reset so requester 0 wins the first simultaneous contest.
REQ-017 MAC SHALL use one DW x DW unsigned multiplier and one 2*DW+1 bit accumulator, 8 steps on edges E1..E8 (step counter 0..7).
REQ-018 Step order: c00=a00*b00+a01*b10, c01=a00*b01+a01*b11, c10=a10*b00+a11*b10, c11=a10*b01+a11*b11; even step loads the product, odd step adds it and writes the element to an internal buffer.
REQ-019 Any written element sum > 2^DW-1 SHALL set an internal overflow flag, cleared at grant.
REQ-020 At E8 the FSM SHALL enter DONE: buffer copied to res, ovf updated, done of the granted requester high for exactly one cycle.
REQ-021 At E9 the FSM SHALL return to IDLE and deassert busy; the earliest next grant is E10.
REQ-022 Latency: done SHALL be high in the cycle after the 8th edge following the grant edge; throughput one operation per 10 cycles.
REQ-023 Requests arriving while busy SHALL NOT be queued or acknowledged; a held req is considered at the next IDLE.
REQ-024 A req still high after its gnt SHALL be treated as a new request (re-served if it wins arbitration).
REQ-025 Operand changes after the grant edge SHALL NOT affect the in-flight result.
REQ-026 res and ovf SHALL hold their values from DONE until the next DONE.
REQ-027 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously.

Reset
REQ-028 rst low SHALL immediately force IDLE, counter 0, pointer to favor requester 0, and gnt0, gnt1, done0, done1, busy, ovf = 0, res = 0.
REQ-029 Reset mid-MAC SHALL abort the operation with no done pulse; the first grant after release follows REQ-014.

Verification
REQ-030 req0 with a0={1,2,3,4}, b0={5,6,7,8} -> gnt0 pulse, done0 after 8 edges, res=0x13162B32 (19,22,43,50), ovf=0.
REQ-031 req0 and req1 high together from reset -> requester 0 served first, requester 1 granted at E10, done1 with its own result; no overlap.
REQ-032 a0={255,255,0,0}, b0={255,0,255,0} -> c00=130050, res=0x02000000, ovf=1 with done0.
REQ-033 req1 asserted during busy, held -> no gnt1 until IDLE; then gnt1 on the first IDLE edge.
REQ-034 rst low at step 4 -> done never asserted, all outputs 0; new request after release completes correctly.
REQ-035 a0/b0 changed one cycle after gnt0 -> res reflects the latched operands only.
